// File: rtl/heap_alloc_pkg.sv
// -----------------------------------------------------------------------------
// heap_alloc_pkg
//   Shared definitions for the heap array allocator:
//     - default sizing parameters (array-number width, area size, array count,
//       total heap words)
//     - allocator FSM state encoding
//     - request-op encoding carried on req_free
// -----------------------------------------------------------------------------
package heap_alloc_pkg;

  localparam int MEM_ELEM_WIDTH_DEF = 12;
  localparam int N_AREA_DEF         = 7;
  localparam int N_ARRAYS_DEF       = 4;
  localparam int N_HEAP_DEF         = 28;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  // Encoding of req_free
  localparam logic OP_ALLOC = 1'b0;
  localparam logic OP_FREE  = 1'b1;

endpackage : heap_alloc_pkg

// File: rtl/freed_array_stack.sv
// -----------------------------------------------------------------------------
// freed_array_stack
//   LIFO of released array numbers. Push and pop are never asserted in the
//   same cycle; the owner never pushes when full nor pops when empty.
//
//   Ports:
//     clock, reset  : clock, asynchronous active-high reset
//     push, push_data : store push_data on top of the stack
//     pop           : discard the current top entry
//     top           : current top entry (0 when empty)
//     depth         : number of stored entries
//     full, empty   : depth == Depth / depth == 0
// -----------------------------------------------------------------------------
module freed_array_stack #(
  parameter int Width = 12,
  parameter int Depth = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [Width-1:0] push_data,
  input  logic             pop,
  output logic [Width-1:0] top,
  output logic [Width-1:0] depth,
  output logic             full,
  output logic             empty
);

  localparam int AW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0] depth_q;
  logic [Width-1:0] entry_rd [Depth];
  logic [AW-1:0]    top_idx;

  assign empty   = (depth_q == '0);
  assign full    = (depth_q == Width'(Depth));
  assign depth   = depth_q;
  // depth_q-1 always fits the index width while the stack is non-empty
  assign top_idx = AW'(depth_q - 1'b1);
  assign top     = empty ? '0 : entry_rd[top_idx];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      depth_q <= '0;
    end else if (push) begin
      depth_q <= depth_q + 1'b1;
    end else if (pop) begin
      depth_q <= depth_q - 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < Depth; gi++) begin : g_entry
      logic [Width-1:0] entry_q;

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          entry_q <= '0;
        end else if (push && (depth_q == Width'(gi))) begin
          entry_q <= push_data;
        end
      end

      assign entry_rd[gi] = entry_q;
    end
  endgenerate

endmodule : freed_array_stack

// File: rtl/heap_array_allocator.sv
// -----------------------------------------------------------------------------
// heap_array_allocator
//   Serves "array" (allocate) and "free" requests for the zero-VM core. An
//   array number N owns heap words N*NArea .. N*NArea+NArea-1. Released
//   numbers are reused LIFO before fresh numbers are drawn from the
//   high-water counter. Also holds the per-array size table.
//
//   Optional feature macro: HEAP_ALLOC_CLEAR_EN
//     defined   : every successful allocate zeroes its heap area (NArea
//                 writes on heap_we/heap_addr/heap_wdata) before responding
//     undefined : heap write port tied to 0, response one cycle after accept
//
//   Ports:
//     clock, reset          : clock, asynchronous active-high reset
//     req_valid/req_ready   : request handshake (ready only in IDLE)
//     req_free, req_array   : 0 = allocate, 1 = free req_array
//     rsp_valid             : one-cycle response pulse
//     rsp_array, rsp_error  : result, held between pulses
//     len_we/len_array/len_index : element write, grows size table entry
//     size_array/size_data  : combinational size-table read
//     heap_we/heap_addr/heap_wdata : heap clear write port
//     allocs                : high-water count of issued numbers
//     freed_top             : freed-stack depth
// -----------------------------------------------------------------------------
module heap_array_allocator
  import heap_alloc_pkg::*;
#(
  parameter int MemoryElementWidth = MEM_ELEM_WIDTH_DEF,
  parameter int NArea              = N_AREA_DEF,
  parameter int NArrays            = N_ARRAYS_DEF,
  parameter int NHeap              = N_HEAP_DEF
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_free,
  input  logic [MemoryElementWidth-1:0] req_array,
  output logic                          rsp_valid,
  output logic [MemoryElementWidth-1:0] rsp_array,
  output logic                          rsp_error,
  input  logic                          len_we,
  input  logic [MemoryElementWidth-1:0] len_array,
  input  logic [MemoryElementWidth-1:0] len_index,
  input  logic [MemoryElementWidth-1:0] size_array,
  output logic [MemoryElementWidth-1:0] size_data,
  output logic                          heap_we,
  output logic [MemoryElementWidth-1:0] heap_addr,
  output logic [MemoryElementWidth-1:0] heap_wdata,
  output logic [MemoryElementWidth-1:0] allocs,
  output logic [MemoryElementWidth-1:0] freed_top
);

  localparam int MW = MemoryElementWidth;
  localparam int AW = (NArrays > 1) ? $clog2(NArrays) : 1;

  generate
    if (NHeap != NArea * NArrays) begin : g_cfg_check
      $error("heap_array_allocator: NHeap must equal NArea*NArrays");
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_e          state_q;
  logic            req_ready_q;
  logic            rsp_valid_q;
  logic [MW-1:0]   rsp_array_q;
  logic            rsp_error_q;
  logic [MW-1:0]   allocs_q;

  // ---------------------------------------------------------------------------
  // Freed-number stack
  // ---------------------------------------------------------------------------
  logic          stk_push;
  logic          stk_pop;
  logic [MW-1:0] stk_top;
  logic [MW-1:0] stk_depth;
  logic          stk_full;
  logic          stk_empty;

  freed_array_stack #(
    .Width (MW),
    .Depth (NArrays)
  ) u_freed_stack (
    .clock     (clock),
    .reset     (reset),
    .push      (stk_push),
    .push_data (req_array),
    .pop       (stk_pop),
    .top       (stk_top),
    .depth     (stk_depth),
    .full      (stk_full),
    .empty     (stk_empty)
  );

  // ---------------------------------------------------------------------------
  // Request decode. All bookkeeping (stack, counter, size zeroing) commits on
  // the accepting edge; only the response is deferred.
  // ---------------------------------------------------------------------------
  logic          accept;
  logic          is_alloc;
  logic          from_stack;
  logic          cnt_avail;
  logic          alloc_ok;
  logic          free_ok;
  logic [MW-1:0] alloc_num;
  logic [MW-1:0] res_array_d;
  logic          res_error_d;
  logic [MW-1:0] allocs_d;

  assign accept     = req_valid && req_ready_q;
  assign is_alloc   = (req_free == OP_ALLOC);
  assign from_stack = !stk_empty;
  assign cnt_avail  = (allocs_q < MW'(NArrays));
  assign alloc_num  = from_stack ? stk_top : allocs_q;
  assign alloc_ok   = accept && is_alloc && (from_stack || cnt_avail);
  assign free_ok    = accept && (req_free == OP_FREE) &&
                      (req_array < allocs_q) && !stk_full;

  assign stk_push   = free_ok;
  assign stk_pop    = alloc_ok && from_stack;

  assign allocs_d    = (alloc_ok && !from_stack) ? allocs_q + 1'b1 : allocs_q;
  assign res_array_d = is_alloc ? (alloc_ok ? alloc_num : '0) : req_array;
  assign res_error_d = is_alloc ? !alloc_ok : !free_ok;

  // ---------------------------------------------------------------------------
  // Optional heap clear datapath
  // ---------------------------------------------------------------------------
`ifdef HEAP_ALLOC_CLEAR_EN
  localparam logic [MW-1:0] NAREA_W = MW'(NArea);

  logic          heap_we_q;
  logic [MW-1:0] heap_addr_q;
  logic [MW-1:0] clr_cnt_q;
  logic [MW-1:0] pend_array_q;
  logic [MW-1:0] base_addr;
  logic          clr_last;

  assign base_addr  = alloc_num * NAREA_W;
  assign clr_last   = (clr_cnt_q == MW'(NArea - 1));
  assign heap_we    = heap_we_q;
  assign heap_addr  = heap_addr_q;
  assign heap_wdata = '0;
`else
  assign heap_we    = 1'b0;
  assign heap_addr  = '0;
  assign heap_wdata = '0;
`endif

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      req_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_array_q  <= '0;
      rsp_error_q  <= 1'b0;
      allocs_q     <= '0;
`ifdef HEAP_ALLOC_CLEAR_EN
      heap_we_q    <= 1'b0;
      heap_addr_q  <= '0;
      clr_cnt_q    <= '0;
      pend_array_q <= '0;
`endif
    end else begin
      rsp_valid_q <= 1'b0;
      allocs_q    <= allocs_d;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            req_ready_q <= 1'b0;
`ifdef HEAP_ALLOC_CLEAR_EN
            // Only successful allocates clear; failures respond directly
            if (alloc_ok) begin
              state_q      <= ST_CLEAR;
              heap_we_q    <= 1'b1;
              heap_addr_q  <= base_addr;
              clr_cnt_q    <= '0;
              pend_array_q <= alloc_num;
            end else
`endif
            begin
              state_q     <= ST_RESP;
              rsp_valid_q <= 1'b1;
              rsp_array_q <= res_array_d;
              rsp_error_q <= res_error_d;
            end
          end
        end

        ST_CLEAR: begin
`ifdef HEAP_ALLOC_CLEAR_EN
          if (clr_last) begin
            state_q     <= ST_RESP;
            heap_we_q   <= 1'b0;
            heap_addr_q <= '0;
            rsp_valid_q <= 1'b1;
            rsp_array_q <= pend_array_q;
            rsp_error_q <= 1'b0;
          end else begin
            clr_cnt_q   <= clr_cnt_q + 1'b1;
            heap_addr_q <= heap_addr_q + 1'b1;
          end
`else
          state_q     <= ST_IDLE;
          req_ready_q <= 1'b1;
`endif
        end

        ST_RESP: begin
          state_q     <= ST_IDLE;
          req_ready_q <= 1'b1;
        end

        default: begin
          state_q     <= ST_IDLE;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_array = rsp_array_q;
  assign rsp_error = rsp_error_q;
  assign allocs    = allocs_q;
  assign freed_top = stk_depth;

  // ---------------------------------------------------------------------------
  // Size table. An allocation zeroing an entry beats a same-cycle length
  // update to it. Length growth is modulo 2^MW, so index all-ones yields 0
  // and never grows the entry.
  // ---------------------------------------------------------------------------
  logic [MW-1:0] len_plus1;
  logic [MW-1:0] size_rd [NArrays];

  assign len_plus1 = len_index + 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < NArrays; gi++) begin : g_size
      logic [MW-1:0] size_q;

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          size_q <= '0;
        end else if (alloc_ok && (alloc_num == MW'(gi))) begin
          size_q <= '0;
        end else if (len_we && (len_array == MW'(gi)) && (size_q < len_plus1)) begin
          size_q <= len_plus1;
        end
      end

      assign size_rd[gi] = size_q;
    end
  endgenerate

  assign size_data = (size_array < MW'(NArrays)) ? size_rd[size_array[AW-1:0]] : '0;

endmodule : heap_array_allocator

// File: tb/tb_heap_array_allocator.sv
module tb_heap_array_allocator;

  localparam int MW = 12;
`ifdef HEAP_ALLOC_CLEAR_EN
  localparam int CLR_LAT = 8;
`else
  localparam int CLR_LAT = 1;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_free = 1'b0;
  logic [MW-1:0] req_array = '0;
  logic          rsp_valid;
  logic [MW-1:0] rsp_array;
  logic          rsp_error;
  logic          len_we = 1'b0;
  logic [MW-1:0] len_array = '0;
  logic [MW-1:0] len_index = '0;
  logic [MW-1:0] size_array = '0;
  logic [MW-1:0] size_data;
  logic          heap_we;
  logic [MW-1:0] heap_addr;
  logic [MW-1:0] heap_wdata;
  logic [MW-1:0] allocs;
  logic [MW-1:0] freed_top;

  heap_array_allocator dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_free   (req_free),
    .req_array  (req_array),
    .rsp_valid  (rsp_valid),
    .rsp_array  (rsp_array),
    .rsp_error  (rsp_error),
    .len_we     (len_we),
    .len_array  (len_array),
    .len_index  (len_index),
    .size_array (size_array),
    .size_data  (size_data),
    .heap_we    (heap_we),
    .heap_addr  (heap_addr),
    .heap_wdata (heap_wdata),
    .allocs     (allocs),
    .freed_top  (freed_top)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic          fr;
    logic [MW-1:0] arr;
    logic          chk_arr;
    logic [MW-1:0] exp_arr;
    logic          exp_err;
    logic [MW-1:0] exp_allocs;
    logic [MW-1:0] exp_ft;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = 1'b0;
    len_we    = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic wait_ready();
    int g = 0;
    @(negedge clock);
    while (!req_ready && g < 50) begin
      @(negedge clock);
      g++;
    end
    if (!req_ready) chk("req_ready_timeout", 0, 1);
  endtask

  // Issue one request; returns the response and cycles from accept to rsp_valid
  task automatic do_req(input logic fr, input logic [MW-1:0] arr,
                        output logic [MW-1:0] a, output logic e, output int lat);
    wait_ready();
    req_valid = 1'b1;
    req_free  = fr;
    req_array = arr;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    req_free  = 1'b0;
    req_array = '0;
    lat = 1;
    while (!rsp_valid && lat < 50) begin
      @(posedge clock);
      #1;
      lat++;
    end
    a = rsp_array;
    e = rsp_error;
  endtask

  task automatic len_write(input logic [MW-1:0] arr, input logic [MW-1:0] idx);
    @(negedge clock);
    len_we    = 1'b1;
    len_array = arr;
    len_index = idx;
    @(negedge clock);
    len_we = 1'b0;
  endtask

  initial begin
    logic [MW-1:0] a;
    logic          e;
    int            lat;
    int            seen;

    //             fr    arr  chk  exp  err  allocs ft
    tbl[0]  = '{1'b0, 12'd0, 1'b1, 12'd0, 1'b0, 12'd1, 12'd0};
    tbl[1]  = '{1'b0, 12'd0, 1'b1, 12'd1, 1'b0, 12'd2, 12'd0};
    tbl[2]  = '{1'b0, 12'd0, 1'b1, 12'd2, 1'b0, 12'd3, 12'd0};
    tbl[3]  = '{1'b0, 12'd0, 1'b1, 12'd3, 1'b0, 12'd4, 12'd0};
    tbl[4]  = '{1'b0, 12'd0, 1'b1, 12'd0, 1'b1, 12'd4, 12'd0};  // exhausted
    tbl[5]  = '{1'b1, 12'd2, 1'b1, 12'd2, 1'b0, 12'd4, 12'd1};
    tbl[6]  = '{1'b1, 12'd0, 1'b1, 12'd0, 1'b0, 12'd4, 12'd2};
    tbl[7]  = '{1'b0, 12'd0, 1'b1, 12'd0, 1'b0, 12'd4, 12'd1};  // LIFO pop
    tbl[8]  = '{1'b0, 12'd0, 1'b1, 12'd2, 1'b0, 12'd4, 12'd0};
    tbl[9]  = '{1'b1, 12'd7, 1'b0, 12'd0, 1'b1, 12'd4, 12'd0};  // never issued
    tbl[10] = '{1'b1, 12'd0, 1'b1, 12'd0, 1'b0, 12'd4, 12'd1};
    tbl[11] = '{1'b1, 12'd1, 1'b1, 12'd1, 1'b0, 12'd4, 12'd2};
    tbl[12] = '{1'b1, 12'd2, 1'b1, 12'd2, 1'b0, 12'd4, 12'd3};
    tbl[13] = '{1'b1, 12'd3, 1'b1, 12'd3, 1'b0, 12'd4, 12'd4};
    tbl[14] = '{1'b1, 12'd1, 1'b0, 12'd0, 1'b1, 12'd4, 12'd4};  // stack full
    tbl[15] = '{1'b0, 12'd0, 1'b1, 12'd3, 1'b0, 12'd4, 12'd3};

    // ---------------- reset state ----------------
    do_reset();
    #1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_array", rsp_array, 0);
    chk("rst_rsp_error", rsp_error, 0);
    chk("rst_allocs", allocs, 0);
    chk("rst_freed_top", freed_top, 0);
    chk("rst_heap_we", heap_we, 0);
    chk("rst_size_data", size_data, 0);

    // ---------------- table-driven requests ----------------
    for (int i = 0; i < 16; i++) begin
      do_req(tbl[i].fr, tbl[i].arr, a, e, lat);
      $display("vec %0d: free=%0d arr=%0d -> rsp_array=%0d rsp_error=%0d lat=%0d allocs=%0d freed_top=%0d",
               i, tbl[i].fr, tbl[i].arr, a, e, lat, allocs, freed_top);
      chk($sformatf("v%0d_err", i), e, tbl[i].exp_err);
      if (tbl[i].chk_arr) chk($sformatf("v%0d_arr", i), a, tbl[i].exp_arr);
      chk($sformatf("v%0d_allocs", i), allocs, tbl[i].exp_allocs);
      chk($sformatf("v%0d_freed_top", i), freed_top, tbl[i].exp_ft);
      chk($sformatf("v%0d_latency", i), lat,
          (!tbl[i].fr && !tbl[i].exp_err) ? CLR_LAT : 1);
`ifndef HEAP_ALLOC_CLEAR_EN
      chk($sformatf("v%0d_heap_we", i), heap_we, 0);
`endif
      @(posedge clock);
      #1;
      chk($sformatf("v%0d_pulse", i), rsp_valid, 0);
      if (tbl[i].chk_arr) chk($sformatf("v%0d_hold", i), rsp_array, tbl[i].exp_arr);
    end

    // ---------------- free beyond high-water mark ----------------
    do_reset();
    do_req(1'b0, '0, a, e, lat);
    do_req(1'b0, '0, a, e, lat);
    do_req(1'b1, 12'd3, a, e, lat);
    $display("free 3 with allocs=%0d -> rsp_error=%0d freed_top=%0d", allocs, e, freed_top);
    chk("free_oob_err", e, 1);
    chk("free_oob_ft", freed_top, 0);
    chk("free_oob_allocs", allocs, 2);

    // ---------------- length updates ----------------
    size_array = 12'd1;
    len_write(12'd1, 12'd2);
    chk("len_idx2", size_data, 3);
    len_write(12'd1, 12'd0);
    chk("len_idx0", size_data, 3);
    len_write(12'd1, 12'd5);
    chk("len_idx5", size_data, 6);
    len_write(12'd1, 12'd3);
    chk("len_idx3", size_data, 6);
    $display("len writes 2,0,5,3 on array 1 -> size_data=%0d", size_data);
    len_write(12'd1, 12'hFFF);   // index+1 wraps to 0, no growth
    chk("len_wrap", size_data, 6);
    len_write(12'd3, 12'd8);
    size_array = 12'd3;
    #1;
    chk("len_arr3", size_data, 9);
    size_array = 12'd7;          // aliases entry 3 in the low bits
    #1;
    chk("size_oob7", size_data, 0);
    size_array = 12'd4;
    #1;
    chk("size_oob4", size_data, 0);
    size_array = 12'd1;

    // ---------------- allocate beats same-cycle len_we ----------------
    do_req(1'b1, 12'd1, a, e, lat);
    chk("free1_ft", freed_top, 1);
    wait_ready();
    req_valid = 1'b1;
    req_free  = 1'b0;
    len_we    = 1'b1;
    len_array = 12'd1;
    len_index = 12'd4;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    len_we    = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 50) begin
      @(posedge clock);
      #1;
      lat++;
    end
    $display("alloc with len_we idx 4 -> rsp_array=%0d size_data=%0d", rsp_array, size_data);
    chk("race_arr", rsp_array, 1);
    chk("race_err", rsp_error, 0);
    chk("race_size", size_data, 0);
    chk("race_ft", freed_top, 0);

`ifdef HEAP_ALLOC_CLEAR_EN
    // ---------------- heap clear sequence ----------------
    do_reset();
    do_req(1'b0, '0, a, e, lat);
    wait_ready();
    req_valid = 1'b1;
    req_free  = 1'b0;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    for (int k = 0; k < 7; k++) begin
      $display("clear cycle %0d: heap_we=%0d heap_addr=%0d heap_wdata=%0d", k, heap_we, heap_addr, heap_wdata);
      chk($sformatf("clr%0d_we", k), heap_we, 1);
      chk($sformatf("clr%0d_addr", k), heap_addr, 7 + k);
      chk($sformatf("clr%0d_wdata", k), heap_wdata, 0);
      chk($sformatf("clr%0d_novalid", k), rsp_valid, 0);
      @(posedge clock);
      #1;
    end
    chk("clr_rsp_valid", rsp_valid, 1);
    chk("clr_rsp_array", rsp_array, 1);
    chk("clr_heap_we_off", heap_we, 0);

    // ---------------- reset during clear ----------------
    wait_ready();
    req_valid = 1'b1;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    repeat (2) begin
      @(posedge clock);
      #1;
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rstclr_ready", req_ready, 1);
    chk("rstclr_allocs", allocs, 0);
    chk("rstclr_heap_we", heap_we, 0);
    seen = 0;
    repeat (12) begin
      @(posedge clock);
      #1;
      if (rsp_valid) seen++;
    end
    $display("reset in clear -> rsp_valid pulses=%0d req_ready=%0d allocs=%0d", seen, req_ready, allocs);
    chk("rstclr_no_rsp", seen, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_heap_array_allocator
